// File: rtl/config_loader.sv
// Serial configuration-chain loader: accepts words on a valid/ready port and shifts
// them MSB-first onto the chain, asserting config_en for exactly CHAIN_LENGTH cycles.
module config_loader #(
    parameter int WORD_WIDTH   = 16,
    parameter int CHAIN_LENGTH = 40,
    parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  config_clk,
    input  logic                  sys_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_out,
    output logic                  config_en,
    input  logic                  chain_tail,
    output logic [CNT_WIDTH-1:0]  bit_count,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg,
    output logic                  tail_dbg
);
    localparam int WCW = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] CL_C   = CNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [CNT_WIDTH-1:0] CL_M1  = CNT_WIDTH'(CHAIN_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t                 state, state_nxt;
    logic [WORD_WIDTH-1:0]  sreg;
    logic [WCW-1:0]         wcnt;
    logic [WCW-1:0]         fill;
    logic [CNT_WIDTH-1:0]   remain;
    logic                   last_bit, final_bit, take_word;

    // Handshake: a word transfers on a rising edge where word_ready and word_valid
    // are both high; word_ready depends only on internal state, never on word_valid.
    always_comb begin
        last_bit   = (state == SHIFT) && (wcnt == WCW'(1));
        final_bit  = (state == SHIFT) && (bit_count == CL_M1);
        word_ready = (state == FETCH) || (last_bit && !final_bit);
        take_word  = word_ready && word_valid;
        remain     = CL_C - bit_count - ((state == SHIFT) ? CNT_WIDTH'(1) : '0);
        if (32'(remain) >= WORD_WIDTH) fill = WCW'(WORD_WIDTH);
        else                           fill = WCW'(remain);

        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: if (word_valid) state_nxt = SHIFT;
            SHIFT: begin
                if (final_bit)     state_nxt = DONE;
                else if (last_bit) state_nxt = take_word ? SHIFT : FETCH;
            end
            DONE:  if (start && !busy) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge config_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state      <= IDLE;
            sreg       <= '0;
            wcnt       <= '0;
            bit_count  <= '0;
            config_out <= 1'b0;
            config_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tail_dbg   <= 1'b0;
        end else begin
            tail_dbg <= chain_tail;
            if (abort) begin
                state      <= IDLE;
                sreg       <= '0;
                wcnt       <= '0;
                bit_count  <= '0;
                config_out <= 1'b0;
                config_en  <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                state <= state_nxt;
                case (state)
                    IDLE: begin
                        if (start) begin
                            bit_count <= '0;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                    FETCH: begin
                        config_en <= 1'b0;
                        if (word_valid) begin
                            sreg <= word_in;
                            wcnt <= fill;
                        end
                    end
                    SHIFT: begin
                        config_en  <= 1'b1;
                        config_out <= sreg[WORD_WIDTH-1];
                        bit_count  <= bit_count + CNT_WIDTH'(1);
                        // Reloading in the last-bit cycle keeps the stream bubble-free.
                        if (take_word) begin
                            sreg <= word_in;
                            wcnt <= fill;
                        end else begin
                            sreg <= {sreg[WORD_WIDTH-2:0], 1'b0};
                            wcnt <= wcnt - WCW'(1);
                        end
                    end
                    DONE: begin
                        config_en <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        if (start && !busy) begin
                            bit_count <= '0;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: a bit-queue model of the loader checked every cycle,
// plus literal bitstream checks and a second instance with a 32-bit chain.
module tb_config_loader;
    localparam int CL = 40;

    logic        clk = 1'b0;
    logic        sys_reset = 1'b0;
    logic        start = 1'b0, abort = 1'b0, word_valid = 1'b0, chain_tail = 1'b0;
    logic [15:0] word_in = '0;
    logic        word_ready, config_out, config_en, busy, done, tail_dbg;
    logic [5:0]  bit_count;
    logic [1:0]  state_dbg;

    logic        b_start = 1'b0, b_valid = 1'b0;
    logic [15:0] b_word = '0;
    logic        b_ready, b_out, b_en, b_busy, b_done, b_tail;
    logic [5:0]  b_count;
    logic [1:0]  b_state;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    config_loader #(.WORD_WIDTH(16), .CHAIN_LENGTH(CL)) dut (
        .config_clk(clk), .sys_reset(sys_reset), .start(start), .abort(abort),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .config_out(config_out), .config_en(config_en), .chain_tail(chain_tail),
        .bit_count(bit_count), .busy(busy), .done(done),
        .state_dbg(state_dbg), .tail_dbg(tail_dbg)
    );

    config_loader #(.WORD_WIDTH(16), .CHAIN_LENGTH(32)) dut_b (
        .config_clk(clk), .sys_reset(sys_reset), .start(b_start), .abort(1'b0),
        .word_in(b_word), .word_valid(b_valid), .word_ready(b_ready),
        .config_out(b_out), .config_en(b_en), .chain_tail(1'b0),
        .bit_count(b_count), .busy(b_busy), .done(b_done),
        .state_dbg(b_state), .tail_dbg(b_tail)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: accepted words become a queue of owed bits; one bit leaves per edge.
    logic       m_busy = 0, m_done = 0, m_en = 0, m_out = 0;
    int         m_bits = 0, m_hs = 0;
    logic       exp_q[$];

    function automatic logic m_ready();
        return m_busy && (m_bits < CL) &&
               (exp_q.size() == 0 || (exp_q.size() == 1 && m_bits + 1 < CL));
    endfunction

    task automatic m_clear();
        m_busy = 0; m_done = 0; m_en = 0; m_bits = 0; exp_q.delete();
    endtask

    initial forever begin
        logic hs;
        int   cap;
        @(posedge clk);
        hs = m_ready() && word_valid;
        if (!sys_reset) m_clear();
        else if (abort) m_clear();
        else if (start && !m_busy) begin
            m_clear(); m_busy = 1; m_hs = 0;
        end else if (m_busy) begin
            m_en = 0;
            if (m_bits == CL && exp_q.size() == 0) begin
                m_busy = 0; m_done = 1;
            end else begin
                if (exp_q.size() > 0) begin
                    m_out = exp_q.pop_front(); m_en = 1; m_bits++;
                end
                if (hs) begin
                    m_hs++;
                    cap = CL - m_bits - exp_q.size();
                    for (int i = 0; i < 16 && i < cap; i++) exp_q.push_back(word_in[15-i]);
                end
            end
        end
    end

    // Per-cycle compare plus observation of the shifted stream.
    logic got_q[$];
    int   cyc = 0, en_cnt = 0, first_en = -1, last_en = -1;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (sys_reset) begin
            chk("config_en", config_en, m_en);
            if (m_en) chk("config_out", config_out, m_out);
            chk("bit_count", bit_count, m_bits);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("word_ready", word_ready, m_ready());
            if (config_en) begin
                got_q.push_back(config_out);
                en_cnt++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
        end
    end

    task automatic clear_obs();
        got_q.delete(); en_cnt = 0; first_en = -1; last_en = -1;
    endtask

    logic [15:0] tab [3] = '{16'hA5C3, 16'h0FF0, 16'hBEEF};
    logic        stop_feed = 0;

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic feed(input int hold_idx, input int hold_cyc);
        int idx = 0, held = 0, n = 0;
        while (!stop_feed && !done && n < 300) begin
            @(negedge clk); n++;
            if (stop_feed) break;
            if (idx < 3 && !(idx == hold_idx && held < hold_cyc)) begin
                word_valid = 1; word_in = tab[idx];
            end else word_valid = 0;
            #1;
            if (word_ready) begin
                if (word_valid) idx++;
                else if (idx == hold_idx) held++;
            end
        end
        word_valid = 0;
        if (!stop_feed) chk("load_done", done, 1'b1);
    endtask

    task automatic check_stream(input string name);
        logic [39:0] s = '0;
        chk({name, "_len"}, got_q.size(), CL);
        foreach (got_q[i]) s = {s[38:0], got_q[i]};
        chk({name, "_bits"}, s, 40'hA5C30FF0BE);
        chk({name, "_en_cnt"}, en_cnt, CL);
    endtask

    task automatic wait_count(input int v);
        int n = 0;
        while (bit_count != 6'(v) && n < 200) begin @(negedge clk); #1; n++; end
        chk("wait_bit_count", bit_count, v);
    endtask

    initial begin
        #12;
        chk("reset_outputs", {word_ready, config_out, config_en, bit_count, busy, done}, 0);
        @(negedge clk); sys_reset = 1;

        // Continuous stream of three words, last one partial.
        clear_obs(); pulse_start(); feed(-1, 0);
        check_stream("stream");
        chk("stream_contiguous", last_en - first_en + 1, CL);
        chk("stream_handshakes", m_hs, 3);
        @(negedge clk); #1;
        chk("done_held", {done, busy, config_en}, 3'b100);

        // Word 2 withheld for three ready cycles.
        clear_obs(); pulse_start(); feed(1, 3);
        check_stream("stall");
        chk("stall_gap", (last_en - first_en + 1) > CL, 1'b1);

        // Abort at bit_count 20, then a clean reload.
        clear_obs(); stop_feed = 0; pulse_start();
        fork
            feed(-1, 0);
            begin
                wait_count(20);
                abort = 1; stop_feed = 1;
                @(negedge clk); abort = 0; #1;
                chk("abort_outputs", {config_en, busy, done, bit_count}, 0);
            end
        join
        stop_feed = 0;
        repeat (2) @(negedge clk);
        clear_obs(); pulse_start(); feed(-1, 0);
        check_stream("reload");

        // Start while busy is ignored.
        clear_obs(); pulse_start();
        fork
            feed(-1, 0);
            begin
                wait_count(10);
                start = 1;
                @(negedge clk); start = 0; #1;
                chk("start_busy_count", bit_count, 11);
            end
        join
        check_stream("busy_start");

        // Start and abort together: abort wins.
        @(negedge clk); start = 1; abort = 1;
        @(negedge clk); start = 0; abort = 0; #1;
        chk("start_abort", {busy, done, state_dbg}, 0);
        repeat (3) @(negedge clk); #1;
        chk("start_abort_idle", {config_en, word_ready, bit_count}, 0);

        // Asynchronous reset in the middle of a shift.
        clear_obs(); pulse_start();
        fork
            feed(-1, 0);
            begin
                wait_count(5);
                #1 sys_reset = 0; stop_feed = 1; #1;
                chk("async_reset", {config_en, busy, done, bit_count, word_ready}, 0);
                @(negedge clk); #2 sys_reset = 1;
            end
        join
        stop_feed = 0;
        @(negedge clk); #1;
        chk("post_reset", {state_dbg, bit_count, busy}, 0);

        // 32-bit chain: two words back to back.
        begin
            logic [15:0] tb_b [2] = '{16'h1234, 16'hABCD};
            logic [31:0] s = '0;
            int idx = 0, rdy = 0, en = 0, f = -1, l = -1, n = 0;
            @(negedge clk); b_start = 1;
            @(negedge clk); b_start = 0;
            while (!b_done && n < 200) begin
                @(negedge clk); n++;
                b_valid = (idx < 2); b_word = (idx < 2) ? tb_b[idx] : 16'h0;
                #1;
                if (b_en) begin s = {s[30:0], b_out}; en++; if (f < 0) f = n; l = n; end
                if (b_ready) begin rdy++; if (b_valid) idx++; end
            end
            b_valid = 0;
            chk("b_done", b_done, 1'b1);
            chk("b_ready_cycles", rdy, 2);
            chk("b_en_cnt", en, 32);
            chk("b_contiguous", l - f + 1, 32);
            chk("b_bits", s, 32'h1234ABCD);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
